// File: rtl/modrm_operand_decoder.sv
// -----------------------------------------------------------------------------
// modrm_operand_decoder
//
// Sequential ModR/M decoder between the instruction prefetch FIFO and the
// general-purpose register file. It pops the ModR/M byte plus any 8/16-bit
// displacement, drives the register-file read selects for the base and index
// registers, forms the 16-bit effective address (base + index + disp, mod 2^16)
// and reports the operand fields to the microcode sequencer.
//
// Handshake: start is accepted only in IDLE (busy=0). A decode ends with a
// single-cycle complete pulse; the result outputs become valid with it and are
// held until the next complete or reset. flush aborts any decode with no pulse.
// A FIFO byte is consumed exactly in a cycle where fifo_rd_en=1.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   start, flush          begin a decode (IDLE only) / synchronous abort
//   fifo_empty            prefetch FIFO has no byte available
//   fifo_rd_data [7:0]    FIFO head byte
//   fifo_rd_en            pop the FIFO head this cycle (combinational)
//   rd_sel [1:0][2:0]     register-file read selects, [0]=base, [1]=index
//   rd_val [1:0][15:0]    register-file read data, one cycle after rd_sel
//   busy, complete        decode in progress / one-cycle result strobe
//   mod_field, reg_field, rm_field, rm_is_reg, bp_as_base, effective_address
//                         registered decode results
//   state_dbg [2:0]       current FSM state, for observation only
// -----------------------------------------------------------------------------
module modrm_operand_decoder (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             flush,
    input  logic             fifo_empty,
    input  logic [7:0]       fifo_rd_data,
    output logic             fifo_rd_en,
    output logic [1:0][2:0]  rd_sel,
    input  logic [1:0][15:0] rd_val,
    output logic             busy,
    output logic             complete,
    output logic [1:0]       mod_field,
    output logic [2:0]       reg_field,
    output logic [2:0]       rm_field,
    output logic             rm_is_reg,
    output logic             bp_as_base,
    output logic [15:0]      effective_address,
    output logic [2:0]       state_dbg
);

    typedef enum logic [2:0] {
        IDLE          = 3'd0,
        FETCH_MODRM   = 3'd1,
        FETCH_DISP_LO = 3'd2,
        FETCH_DISP_HI = 3'd3,
        WAIT_REGS     = 3'd4,
        CALC          = 3'd5
    } state_t;

    localparam logic [2:0] REG_BX = 3'd3;
    localparam logic [2:0] REG_BP = 3'd5;
    localparam logic [2:0] REG_SI = 3'd6;
    localparam logic [2:0] REG_DI = 3'd7;

    state_t state_q, state_d;

    // Working copy of the instruction bytes for the decode in flight.
    logic [1:0]  mod_q;
    logic [2:0]  reg_q, rm_q;
    logic [7:0]  disp_lo_q, disp_hi_q;

    // Result registers, updated only in CALC.
    logic [1:0]  mod_field_q;
    logic [2:0]  reg_field_q, rm_field_q;
    logic        rm_is_reg_q, bp_as_base_q, complete_q;
    logic [15:0] ea_q;

    // Addressing-mode decode of the captured fields.
    logic        is_mem, is_direct, base_used, index_used, uses_bp;
    logic [2:0]  base_reg, index_reg;
    logic [15:0] disp, base_term, index_term, ea_calc;

    // ---------------- next-state / FIFO pop ----------------
    always_comb begin
        state_d    = state_q;
        fifo_rd_en = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) state_d = FETCH_MODRM;
            end
            FETCH_MODRM: begin
                fifo_rd_en = !fifo_empty;
                if (!fifo_empty) begin
                    if (fifo_rd_data[7:6] == 2'b11)
                        state_d = CALC;
                    else if (fifo_rd_data[7:6] != 2'b00 || fifo_rd_data[2:0] == 3'b110)
                        state_d = FETCH_DISP_LO;
                    else
                        state_d = WAIT_REGS;
                end
            end
            FETCH_DISP_LO: begin
                fifo_rd_en = !fifo_empty;
                if (!fifo_empty) state_d = (mod_q == 2'b01) ? CALC : FETCH_DISP_HI;
            end
            FETCH_DISP_HI: begin
                fifo_rd_en = !fifo_empty;
                if (!fifo_empty) state_d = CALC;
            end
            WAIT_REGS: state_d = CALC;
            CALC:      state_d = IDLE;
            default:   state_d = IDLE;
        endcase
        // Abort beats everything, including the pop of the current head byte.
        if (flush) begin
            state_d    = IDLE;
            fifo_rd_en = 1'b0;
        end
    end

    // ---------------- operand decode ----------------
    always_comb begin
        is_mem     = (mod_q != 2'b11);
        is_direct  = (mod_q == 2'b00) && (rm_q == 3'b110);
        // rm=100/101 have no base; rm=11x have no index.
        base_used  = is_mem && !is_direct && (rm_q[2:1] != 2'b10);
        index_used = is_mem && (rm_q[2:1] != 2'b11);
        uses_bp    = (rm_q == 3'b010) || (rm_q == 3'b011) || (rm_q == 3'b110);
        base_reg   = uses_bp ? REG_BP : REG_BX;
        index_reg  = rm_q[0] ? REG_DI : REG_SI;

        rd_sel[0] = 3'd0;
        rd_sel[1] = 3'd0;
        if (state_q != IDLE) begin
            if (base_used)  rd_sel[0] = base_reg;
            if (index_used) rd_sel[1] = index_reg;
        end

        case (mod_q)
            2'b01:   disp = {{8{disp_lo_q[7]}}, disp_lo_q};
            2'b10:   disp = {disp_hi_q, disp_lo_q};
            2'b00:   disp = is_direct ? {disp_hi_q, disp_lo_q} : 16'd0;
            default: disp = 16'd0;
        endcase

        // Unused components are masked so stale rd_val never leaks in.
        base_term  = base_used  ? rd_val[0] : 16'd0;
        index_term = index_used ? rd_val[1] : 16'd0;
        ea_calc    = base_term + index_term + disp;
    end

    // ---------------- state and data registers ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            mod_q        <= 2'd0;
            reg_q        <= 3'd0;
            rm_q         <= 3'd0;
            disp_lo_q    <= 8'd0;
            disp_hi_q    <= 8'd0;
            mod_field_q  <= 2'd0;
            reg_field_q  <= 3'd0;
            rm_field_q   <= 3'd0;
            rm_is_reg_q  <= 1'b0;
            bp_as_base_q <= 1'b0;
            ea_q         <= 16'd0;
            complete_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (fifo_rd_en) begin
                case (state_q)
                    FETCH_MODRM: begin
                        mod_q <= fifo_rd_data[7:6];
                        reg_q <= fifo_rd_data[5:3];
                        rm_q  <= fifo_rd_data[2:0];
                    end
                    FETCH_DISP_LO: disp_lo_q <= fifo_rd_data;
                    FETCH_DISP_HI: disp_hi_q <= fifo_rd_data;
                    default: ;
                endcase
            end
            complete_q <= (state_q == CALC) && !flush;
            if (state_q == CALC && !flush) begin
                mod_field_q  <= mod_q;
                reg_field_q  <= reg_q;
                rm_field_q   <= rm_q;
                rm_is_reg_q  <= !is_mem;
                bp_as_base_q <= base_used && uses_bp;
                ea_q         <= ea_calc;
            end
        end
    end

    assign busy              = (state_q != IDLE);
    assign complete          = complete_q;
    assign mod_field         = mod_field_q;
    assign reg_field         = reg_field_q;
    assign rm_field          = rm_field_q;
    assign rm_is_reg         = rm_is_reg_q;
    assign bp_as_base        = bp_as_base_q;
    assign effective_address = ea_q;
    assign state_dbg         = state_q;

endmodule
